ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Round-robin AHB arbiter that shares one AHB bus among NUM_MASTERS masters feeding the slave fabric.
- Drives the grant lines, the address-phase and data-phase master IDs, and the lock indication.
- Handles SPLIT from slaves: split_in masks the data-phase master, valid_aft_split_in releases it.
- Sits between the master request lines and the address/control mux in front of the slave decoder.

Parameters:
- NUM_MASTERS, 4, number of requesting masters; allowed range 2..8.
- DEFAULT_MASTER, 0, master parked on the bus when no unmasked request is pending.
- MAX_TENURE, 16, cycles a non-locked owner may hold the bus; used only with ARB_TENURE_LIMIT_EN.

Ports:
- hclk  in  1  bus clock; all logic on the rising edge.
- hreset  in  1  synchronous, active-high reset.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-transfer request.
- htrans  in  2  transfer type on the muxed address phase.
- hready  in  1  muxed transfer-done from the slaves.
- split_in  in  1  slave has split the current data-phase transfer.
- valid_aft_split_in  in  1  slave is ready to resume split masters.
- hgrant  out  NUM_MASTERS  one-hot grant.
- hmaster  out  $clog2(NUM_MASTERS)  address-phase owner ID.
- hmaster_data  out  $clog2(NUM_MASTERS)  data-phase owner ID.
- hmastlock  out  1  current address phase is locked.
- split_mask  out  NUM_MASTERS  masters currently blocked by SPLIT.

Behaviour:
- Clock and reset: one clock, hclk. hreset is synchronous and active-high.
- Reset values:
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = hmaster_data = DEFAULT_MASTER.
  - hmastlock = 0; split_mask = 0; rr_ptr = DEFAULT_MASTER; state = PARK; tenure counter = 0.
- Reset mid-transfer discards any grant, lock or split state immediately.
- Eligible set: hbusreq & ~split_mask.
- Round-robin pick: first eligible index scanning from rr_ptr+1 upward, modulo NUM_MASTERS. The previous owner is selected last.
- States and transitions:
  - PARK: grant on DEFAULT_MASTER.
    - Eligible != 0 and hready=1 -> grant the pick; go to OWN, or to LOCK if hlock[pick]=1.
  - OWN: owner keeps the grant while hbusreq[owner]=1.
    - On an hready=1 edge, if hbusreq[owner]=0 or owner is masked: re-pick. Eligible=0 -> PARK.
  - LOCK: entered when hlock[owner]=1 on an hready=1 edge.
    - No re-arbitration while hlock[owner]=1.
    - Leaves to OWN/PARK rules on the first hready=1 edge where hlock[owner]=0 and htrans != NONSEQ/SEQ.
- Grant timing:
  - hgrant and state change only on edges with hready=1.
  - A pick registers hgrant one cycle after the request is seen.
  - rr_ptr <= new owner on each grant change.
- ID pipeline:
  - hmaster <= granted index on every hready=1 edge, so it lags hgrant by one hready cycle.
  - hmaster_data <= hmaster on every hready=1 edge.
  - hmastlock <= (state==LOCK) on the same edge as hmaster.
- SPLIT:
  - split_in=1 on any edge: split_mask[hmaster_data] <= 1.
  - If that master owns the grant, it loses it on the next hready=1 edge; LOCK is abandoned.
  - valid_aft_split_in=1: split_mask <= 0.
  - Both in the same cycle: the clear applies first, then the new bit is set.
- All masters masked, or no requests: park on DEFAULT_MASTER even if DEFAULT_MASTER is masked.
- hready=0: every register holds except split_mask, which updates regardless of hready.
- htrans encodings: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.

Optional Feature:
- Macro: ARB_TENURE_LIMIT_EN.
- Defined:
  - An 8-bit-saturating tenure counter increments on every hready=1 edge in OWN and clears on each grant change.
  - When the count reaches MAX_TENURE-1, a re-arbitration is forced on the next hready=1 edge even if hbusreq[owner]=1.
  - If no other master is eligible, the owner is re-granted and the counter clears.
  - LOCK is exempt from the limit.
- Undefined: no counter; an OWN owner keeps the bus indefinitely while requesting.

Decomposition:
- Package ahb_arb_pkg:
  - htrans localparams (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - Arbiter state enum (ARB_PARK, ARB_OWN, ARB_LOCK).
  - Function clog2_min1 for ID width.
- Sub-module ahb_rr_picker: combinational.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: pick index, pick_valid.
  - Reused by the slave-side split scheduler.

Test Plan:
- Reset: hreset=1 for 2 cycles -> hgrant=4'b0001, hmaster=0, hmastlock=0, split_mask=0.
- Fairness: hbusreq=4'b1111 held, each owner drops hbusreq after 2 hready cycles -> grant order 1,2,3,0,1.
- Lock: master 2 holds hlock=1 with hbusreq=4'b1110 for 10 cycles -> hgrant stays 4'b0100 and hmastlock=1 for the whole tenure.
- Split:
  - hmaster_data=1 and split_in pulse -> split_mask=4'b0010; master 1 never granted while masked despite hbusreq[1]=1.
  - valid_aft_split_in pulse -> split_mask=0; master 1 granted on its next turn.
- Wait states: hready=0 for 5 cycles while hbusreq changes -> hgrant, hmaster and hmaster_data frozen; new grant appears on the first hready=1 edge.
- ARB_TENURE_LIMIT_EN with MAX_TENURE=4: master 0 and master 3 both requesting continuously -> grant alternates every 4 hready cycles.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared htrans encodings, arbiter state type and ID-width helper for the AHB bus arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ARB_PARK = 2'd0,
    ARB_OWN  = 2'd1,
    ARB_LOCK = 2'd2
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: nearest eligible index above rr_ptr, wrapping, so rr_ptr itself is chosen last.
module ahb_rr_picker
  import ahb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic [IW-1:0] pick,
  output logic          pick_valid
);

  logic [IW-1:0] idx;

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    // Walk from the farthest offset to the nearest so the nearest eligible index wins.
    for (int off = N; off >= 1; off--) begin
      idx = IW'((int'(rr_ptr) + off) % N);
      if (eligible[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with SPLIT masking; grant registers one cycle after a request, IDs pipeline behind it on hready.
// hready low freezes grant/state/IDs (split_mask still updates); ARB_TENURE_LIMIT_EN caps OWN tenure at MAX_TENURE cycles.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int  NUM_MASTERS    = 4,
  parameter int  DEFAULT_MASTER = 0,
  parameter int  MAX_TENURE     = 16,
  localparam int IW             = clog2_min1(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  input  logic                   split_in,
  input  logic                   valid_aft_split_in,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [IW-1:0]          hmaster,
  output logic [IW-1:0]          hmaster_data,
  output logic                   hmastlock,
  output logic [NUM_MASTERS-1:0] split_mask
);

  localparam logic [IW-1:0]          DEF_ID = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] ONE    = NUM_MASTERS'(1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || DEFAULT_MASTER < 0 ||
      DEFAULT_MASTER >= NUM_MASTERS || MAX_TENURE < 1) begin : g_bad_params
    $error("ahb_bus_arbiter: illegal parameter combination");
  end

  arb_state_e             state;
  logic [IW-1:0]          owner;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          next_owner;
  logic                   pick_valid;
  logic                   owner_ok;
  logic                   trans_active;
  logic                   lock_release;
  logic                   tenure_hit;
  logic                   rearb;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] split_nxt;

  assign eligible     = hbusreq & ~split_mask;
  assign owner_ok     = hbusreq[owner] & ~split_mask[owner];
  assign lock_release = ~hlock[owner] & ~trans_active;
  assign next_owner   = pick_valid ? pick : DEF_ID;

  ahb_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .eligible   (eligible),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .pick_valid (pick_valid)
  );

  always_comb begin
    trans_active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  end

  // A split owner abandons even a locked sequence; otherwise LOCK only yields between bursts.
  always_comb begin
    rearb = 1'b0;
    case (state)
      ARB_PARK: rearb = 1'b1;
      ARB_OWN:  rearb = ~owner_ok | tenure_hit;
      ARB_LOCK: rearb = split_mask[owner] | (lock_release & ~owner_ok);
      default:  rearb = 1'b1;
    endcase
  end

  // Clear first, then set, so a split landing with the release is not lost.
  always_comb begin
    split_nxt = valid_aft_split_in ? '0 : split_mask;
    if (split_in) split_nxt = split_nxt | (ONE << hmaster_data);
  end

`ifdef ARB_TENURE_LIMIT_EN
  localparam logic [7:0] TENURE_LAST = 8'(MAX_TENURE - 1);
  logic [7:0] tenure_cnt;

  assign tenure_hit = (state == ARB_OWN) && (tenure_cnt == TENURE_LAST);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      tenure_cnt <= '0;
    end else if (hready) begin
      if (state == ARB_OWN && !rearb)
        tenure_cnt <= (tenure_cnt == 8'hFF) ? tenure_cnt : tenure_cnt + 8'd1;
      else
        tenure_cnt <= '0;
    end
  end
`else
  assign tenure_hit = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state        <= ARB_PARK;
      owner        <= DEF_ID;
      hgrant       <= ONE << DEF_ID;
      rr_ptr       <= DEF_ID;
      hmaster      <= DEF_ID;
      hmaster_data <= DEF_ID;
      hmastlock    <= 1'b0;
      split_mask   <= '0;
    end else begin
      split_mask <= split_nxt;
      if (hready) begin
        hmaster      <= owner;
        hmaster_data <= hmaster;
        hmastlock    <= (state == ARB_LOCK);
        if (rearb) begin
          owner  <= next_owner;
          hgrant <= ONE << next_owner;
          rr_ptr <= next_owner;
          if (!pick_valid)      state <= ARB_PARK;
          else if (hlock[pick]) state <= ARB_LOCK;
          else                  state <= ARB_OWN;
        end else if (state == ARB_OWN && hlock[owner]) begin
          state <= ARB_LOCK;
        end else if (state == ARB_LOCK && lock_release) begin
          state <= ARB_OWN;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: vector table (reset/fairness/wait states), lock/split/tenure sequences, random run vs reference model.
module tb_ahb_bus_arbiter;
  import ahb_arb_pkg::*;

  localparam int NM   = 4;
  localparam int DEF  = 0;
  localparam int MAXT = 4;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [NM-1:0] hbusreq;
  logic [NM-1:0] hlock;
  logic [1:0]    htrans;
  logic          hready;
  logic          split_in;
  logic          valid_aft_split_in;
  logic [NM-1:0] hgrant;
  logic [1:0]    hmaster;
  logic [1:0]    hmaster_data;
  logic          hmastlock;
  logic [NM-1:0] split_mask;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .DEFAULT_MASTER (DEF),
    .MAX_TENURE     (MAXT)
  ) dut (
    .hclk               (hclk),
    .hreset             (hreset),
    .hbusreq            (hbusreq),
    .hlock              (hlock),
    .htrans             (htrans),
    .hready             (hready),
    .split_in           (split_in),
    .valid_aft_split_in (valid_aft_split_in),
    .hgrant             (hgrant),
    .hmaster            (hmaster),
    .hmaster_data       (hmaster_data),
    .hmastlock          (hmastlock),
    .split_mask         (split_mask)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether the bus is parked or locked, and the ID pipeline.
  int       m_owner, m_ptr, m_hm, m_hmd, m_ten;
  bit       m_parked, m_locked, m_hml;
  bit [3:0] m_mask;

  typedef struct {
    bit       rst;
    bit [3:0] req;
    bit       rdy;
    bit [3:0] g;
    int       hm;
    int       hmd;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit [3:0] req, input bit [3:0] lck,
                            input bit [1:0] tr, input bit rdy, input bit spl, input bit vas);
    bit [3:0] elig, nmask;
    bit       own_ok, active, rearb, tenure_up;
    int       p;
    if (rst) begin
      m_owner = DEF; m_ptr = DEF; m_hm = DEF; m_hmd = DEF; m_ten = 0;
      m_parked = 1'b1; m_locked = 1'b0; m_hml = 1'b0; m_mask = '0;
      return;
    end
    nmask = vas ? 4'b0000 : m_mask;
    if (spl) nmask[m_hmd] = 1'b1;
    if (rdy) begin
      elig   = req & ~m_mask;
      own_ok = req[m_owner] && !m_mask[m_owner];
      active = (tr == 2'b10) || (tr == 2'b11);
`ifdef ARB_TENURE_LIMIT_EN
      tenure_up = (m_ten == MAXT - 1);
`else
      tenure_up = 1'b0;
`endif
      if (m_parked)      rearb = 1'b1;
      else if (m_locked) rearb = m_mask[m_owner] || (!lck[m_owner] && !active && !own_ok);
      else               rearb = !own_ok || tenure_up;
      m_hmd = m_hm;
      m_hm  = m_owner;
      m_hml = m_locked;
      if (rearb) begin
        p = -1;
        for (int k = 1; k <= NM; k++)
          if (p < 0 && elig[(m_ptr + k) % NM]) p = (m_ptr + k) % NM;
        if (p < 0) begin
          m_owner = DEF; m_parked = 1'b1; m_locked = 1'b0;
        end else begin
          m_owner = p; m_parked = 1'b0; m_locked = lck[p];
        end
        m_ptr = m_owner;
        m_ten = 0;
      end else if (m_locked) begin
        if (!lck[m_owner] && !active) m_locked = 1'b0;
        m_ten = 0;
      end else begin
        if (lck[m_owner]) m_locked = 1'b1;
        if (m_ten < 255) m_ten++;
      end
    end
    m_mask = nmask;
  endtask

  task automatic step(input bit rst, input bit [3:0] req, input bit [3:0] lck,
                      input bit [1:0] tr, input bit rdy, input bit spl, input bit vas);
    hreset = rst; hbusreq = req; hlock = lck; htrans = tr;
    hready = rdy; split_in = spl; valid_aft_split_in = vas;
    @(posedge hclk);
    model_step(rst, req, lck, tr, rdy, spl, vas);
    @(negedge hclk);
  endtask

  task automatic check_model(input int n);
    bit [3:0] eg;
    eg = '0;
    eg[m_owner] = 1'b1;
    chk($sformatf("rnd%0d_hgrant", n),       32'(hgrant),       32'(eg));
    chk($sformatf("rnd%0d_hmaster", n),      32'(hmaster),      m_hm);
    chk($sformatf("rnd%0d_hmaster_data", n), 32'(hmaster_data), m_hmd);
    chk($sformatf("rnd%0d_hmastlock", n),    32'(hmastlock),    32'(m_hml));
    chk($sformatf("rnd%0d_split_mask", n),   32'(split_mask),   32'(m_mask));
  endtask

  initial begin
    bit       r_rst, r_rdy, r_spl, r_vas;
    bit [3:0] r_req, r_lck;
    bit [1:0] r_tr;

    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = HTRANS_IDLE;
    hready = 1'b1; split_in = 1'b0; valid_aft_split_in = 1'b0;

    // Reset, round-robin fairness 1,2,3,0,1, then wait states and parking.
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0};
    tbl[1]  = '{1'b1, 4'b0000, 1'b1, 4'b0001, 0, 0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 0, 0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1, 0};
    tbl[4]  = '{1'b0, 4'b1101, 1'b1, 4'b0100, 1, 1};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2, 1};
    tbl[6]  = '{1'b0, 4'b1011, 1'b1, 4'b1000, 2, 2};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 3, 2};
    tbl[8]  = '{1'b0, 4'b0111, 1'b1, 4'b0001, 3, 3};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 0, 3};
    tbl[10] = '{1'b0, 4'b1110, 1'b1, 4'b0010, 0, 0};
    tbl[11] = '{1'b0, 4'b1100, 1'b0, 4'b0010, 0, 0};
    tbl[12] = '{1'b0, 4'b0001, 1'b0, 4'b0010, 0, 0};
    tbl[13] = '{1'b0, 4'b1101, 1'b0, 4'b0010, 0, 0};
    tbl[14] = '{1'b0, 4'b0100, 1'b0, 4'b0010, 0, 0};
    tbl[15] = '{1'b0, 4'b1000, 1'b0, 4'b0010, 0, 0};
    tbl[16] = '{1'b0, 4'b1100, 1'b1, 4'b0100, 1, 0};
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0001, 2, 1};
    tbl[18] = '{1'b0, 4'b0000, 1'b1, 4'b0001, 0, 2};

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].req, 4'b0000, HTRANS_IDLE, tbl[i].rdy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_hgrant", i),       32'(hgrant),       32'(tbl[i].g));
      chk($sformatf("vec%0d_hmaster", i),      32'(hmaster),      tbl[i].hm);
      chk($sformatf("vec%0d_hmaster_data", i), 32'(hmaster_data), tbl[i].hmd);
      chk($sformatf("vec%0d_hmastlock", i),    32'(hmastlock),    32'd0);
      chk($sformatf("vec%0d_split_mask", i),   32'(split_mask),   32'd0);
    end

    // Locked tenure of master 2.
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 4'b0100, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
    chk("lock_first_hgrant", 32'(hgrant), 32'(4'b0100));
    chk("lock_first_hmastlock", 32'(hmastlock), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b1110, 4'b0100, HTRANS_SEQ, 1'b1, 1'b0, 1'b0);
      chk($sformatf("lock%0d_hgrant", i),    32'(hgrant),    32'(4'b0100));
      chk($sformatf("lock%0d_hmastlock", i), 32'(hmastlock), 32'd1);
    end
    step(1'b0, 4'b1010, 4'b0000, HTRANS_SEQ, 1'b1, 1'b0, 1'b0);
    chk("lock_midburst_hgrant", 32'(hgrant), 32'(4'b0100));
    step(1'b0, 4'b1010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    chk("lock_release_hgrant", 32'(hgrant), 32'(4'b1000));
    chk("lock_release_hmaster", 32'(hmaster), 32'd2);
    chk("lock_release_hmastlock", 32'(hmastlock), 32'd1);
    step(1'b0, 4'b1010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    chk("lock_after_hmastlock", 32'(hmastlock), 32'd0);

    // SPLIT of master 1, masking while requesting, then release.
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 4'b0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
    chk("split_pre_hmaster_data", 32'(hmaster_data), 32'd1);
    step(1'b0, 4'b1010, 4'b0000, HTRANS_NONSEQ, 1'b1, 1'b1, 1'b0);
    chk("split_set_mask", 32'(split_mask), 32'(4'b0010));
    chk("split_set_hgrant", 32'(hgrant), 32'(4'b0010));
    step(1'b0, 4'b1010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    chk("split_lose_hgrant", 32'(hgrant), 32'(4'b1000));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
      chk($sformatf("split_masked%0d_hgrant", i), 32'(hgrant), 32'(4'b0001));
      chk($sformatf("split_masked%0d_mask", i), 32'(split_mask), 32'(4'b0010));
    end
    step(1'b0, 4'b0010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b1);
    chk("split_clear_mask", 32'(split_mask), 32'd0);
    chk("split_clear_hgrant", 32'(hgrant), 32'(4'b0001));
    step(1'b0, 4'b0010, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    chk("split_regrant_hgrant", 32'(hgrant), 32'(4'b0010));

    // Masters 0 and 3 requesting continuously.
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'b1001, 4'b0000, HTRANS_NONSEQ, 1'b1, 1'b0, 1'b0);
`ifdef ARB_TENURE_LIMIT_EN
      chk($sformatf("tenure%0d_hgrant", i), 32'(hgrant),
          32'(((i / MAXT) % 2 == 0) ? 4'b1000 : 4'b0001));
`else
      chk($sformatf("tenure%0d_hgrant", i), 32'(hgrant), 32'(4'b1000));
`endif
    end

    // Randomized traffic against the reference model.
    step(1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, 1'b1, 1'b0, 1'b0);
    check_model(-1);
    for (int n = 0; n < 600; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_req = 4'($urandom());
      r_lck = ($urandom_range(0, 3) == 0) ? (4'($urandom()) & r_req) : 4'b0000;
      r_tr  = 2'($urandom());
      r_rdy = ($urandom_range(0, 3) != 0);
      r_spl = ($urandom_range(0, 11) == 0);
      r_vas = ($urandom_range(0, 9) == 0);
      step(r_rst, r_req, r_lck, r_tr, r_rdy, r_spl, r_vas);
      check_model(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
